// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    // Frame parser states, in the order the frame fields arrive.
    typedef enum logic [2:0] {
        IDLE,
        AH,
        AL,
        LH,
        LL,
        DATA,
        CHK
    } state_t;

    // Default frame start marker.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Width of the LEN field in the frame header.
    localparam int unsigned LEN_WIDTH = 16;

    // Value the running byte sum must reach after the CHK byte.
    localparam logic [7:0] CHK_GOOD = 8'h00;

    // Running 8-bit checksum update.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter with clear and a single-cycle expiry flag.
module loader_timeout #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Flag in the last counting cycle so a registered consumer reacts exactly one cycle later.
    assign expired = enable && !load && (count == WIDTH'(1));

    // Reload on load, drop to zero on clear, otherwise count down while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader driving the instruction RAM write port.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  w_en,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT + 1);

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  timed_out;
    logic                  write_next;
    logic                  done_next;
    logic                  err_next;
    logic [7:0]            addr_hi;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len_hi;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [7:0]            chk_acc;
    logic [LEN_WIDTH-1:0]  frame_len;
    logic [7:0]            chk_sum;

    assign rx_ready  = !rst;
    assign accept    = rx_valid && rx_ready;
    assign busy      = (state != IDLE);
    assign frame_len = {len_hi, rx_data};
    assign chk_sum   = chk_add(chk_acc, rx_data);

    // Idle-gap watchdog: reloaded by every accepted byte, counts only inside a frame.
    loader_timeout #(
        .WIDTH(TIMER_WIDTH)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_value(TIMER_WIDTH'(TIMEOUT - 1)),
        .clear     (!busy),
        .enable    (busy),
        .expired   (timed_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the registered strobes it requests.
    always_comb begin
        state_next = state;
        write_next = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        if (timed_out) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end else if (accept) begin
            case (state)
                IDLE: if (rx_data == SYNC_BYTE) state_next = AH;
                AH:   state_next = AL;
                AL:   state_next = LH;
                LH:   state_next = LL;
                LL:   state_next = (frame_len == '0) ? CHK : DATA;
                DATA: begin
                    write_next = 1'b1;
                    if (remaining == LEN_WIDTH'(1)) state_next = CHK;
                end
                CHK: begin
                    if (chk_sum == CHK_GOOD) done_next = 1'b1;
                    else                     err_next  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame fields, checksum, write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hi   <= '0;
            addr      <= '0;
            len_hi    <= '0;
            remaining <= '0;
            chk_acc   <= '0;
            w_addr    <= '0;
            din       <= '0;
            w_en      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b0;
        end else begin
            w_en <= write_next;
            done <= done_next;
            err  <= err_next;
            if (accept) begin
                case (state)
                    IDLE: chk_acc <= '0;
                    AH: begin
                        addr_hi <= rx_data;
                        chk_acc <= chk_sum;
                    end
                    AL: begin
                        addr    <= ADDR_WIDTH'({addr_hi, rx_data});
                        chk_acc <= chk_sum;
                    end
                    LH: begin
                        len_hi  <= rx_data;
                        chk_acc <= chk_sum;
                    end
                    LL: begin
                        remaining <= frame_len;
                        chk_acc   <= chk_sum;
                    end
                    DATA: begin
                        w_addr    <= addr;
                        din       <= DATA_WIDTH'(rx_data);
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        chk_acc   <= chk_sum;
                    end
                    default: ;
                endcase
            end
            // A new frame start wins over the release that follows a done pulse.
            if (accept && (state == IDLE) && (rx_data == SYNC_BYTE)) begin
                cpu_hold <= 1'b1;
            end else if (done) begin
                cpu_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a frame-level reference model.
module tb_imem_loader;

    localparam int unsigned TO = 16;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] w_addr;
    logic [7:0]  din;
    logic        w_en;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int fails  = 0;

    imem_loader #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .w_addr  (w_addr),
        .din     (din),
        .w_en    (w_en),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one cycle; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Drive one complete frame and check every cycle against the frame-level model.
    // chk_force: -1 correct checksum, -2 corrupted checksum, otherwise the literal CHK byte.
    task automatic run_frame(input string name, input logic [15:0] a, input bq_t pay,
                             input int chk_force, input bit gaps);
        bq_t         hdr;
        logic [15:0] len;
        int unsigned sum;
        logic [7:0]  chk;
        bit          good;
        int unsigned g;
        len = 16'(pay.size());
        hdr = {a[15:8], a[7:0], len[15:8], len[7:0]};
        sum = 0;
        foreach (hdr[i]) sum += hdr[i];
        foreach (pay[i]) sum += pay[i];
        if (chk_force == -1)      chk = 8'((256 - (sum % 256)) % 256);
        else if (chk_force == -2) chk = 8'((257 - (sum % 256)) % 256);
        else                      chk = 8'(chk_force);
        good = (((sum + chk) % 256) == 0);

        send_byte(8'hA5);
        checks++;
        if ({cpu_hold, busy, w_en, done, err} !== 5'b11000) begin
            fails++;
            $display("FAIL %s sync: hold/busy/wen/done/err got %b expected 11000", name,
                     {cpu_hold, busy, w_en, done, err});
        end
        foreach (hdr[i]) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                step();
                checks++;
                if ({busy, w_en, err} !== 3'b100) begin
                    fails++;
                    $display("FAIL %s hdr_gap: busy/wen/err got %b expected 100", name, {busy, w_en, err});
                end
            end
            send_byte(hdr[i]);
            checks++;
            if ({busy, w_en, done, err} !== 4'b1000) begin
                fails++;
                $display("FAIL %s hdr%0d: busy/wen/done/err got %b expected 1000", name, i,
                         {busy, w_en, done, err});
            end
        end
        foreach (pay[k]) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                step();
                checks++;
                if ({busy, w_en, err} !== 3'b100) begin
                    fails++;
                    $display("FAIL %s data_gap: busy/wen/err got %b expected 100", name, {busy, w_en, err});
                end
            end
            send_byte(pay[k]);
            checks++;
            if ({w_en, w_addr, din} !== {1'b1, 16'(a + k), pay[k]}) begin
                fails++;
                $display("FAIL %s write%0d: wen/addr/din got %b/%h/%h expected 1/%h/%h", name, k,
                         w_en, w_addr, din, 16'(a + k), pay[k]);
            end
        end
        send_byte(chk);
        checks++;
        if ({done, err, busy, w_en, cpu_hold} !== {good, !good, 3'b001}) begin
            fails++;
            $display("FAIL %s chk: done/err/busy/wen/hold got %b expected %b", name,
                     {done, err, busy, w_en, cpu_hold}, {good, !good, 3'b001});
        end
        step();
        checks++;
        if ({done, err, cpu_hold} !== {2'b00, !good}) begin
            fails++;
            $display("FAIL %s after: done/err/hold got %b expected %b", name,
                     {done, err, cpu_hold}, {2'b00, !good});
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) step();
        checks++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset rx_ready: got %b expected 0", rx_ready);
        end
        checks++;
        if ({w_en, w_addr, din} !== 25'h0) begin
            fails++;
            $display("FAIL reset write_port: got %b/%h/%h expected 0/0000/00", w_en, w_addr, din);
        end
        checks++;
        if ({cpu_hold, busy, done, err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset status: hold/busy/done/err got %b expected 0000", {cpu_hold, busy, done, err});
        end
        rx_valid = 1'b0;
        rst      = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset release rx_ready: got %b expected 1", rx_ready);
        end
    endtask

    task automatic test_good_frame();
        bq_t p;
        send_byte(8'h00);
        send_byte(8'h3C);
        checks++;
        if ({busy, cpu_hold, w_en} !== 3'b000) begin
            fails++;
            $display("FAIL idle_discard: busy/hold/wen got %b expected 000", {busy, cpu_hold, w_en});
        end
        p = {8'h11, 8'h22, 8'h33};
        run_frame("good", 16'h0100, p, 8'h96, 1'b0);
    endtask

    task automatic test_bad_checksum();
        bq_t p;
        p = {8'h11, 8'h22, 8'h33};
        run_frame("bad_chk", 16'h0100, p, 8'h00, 1'b0);
    endtask

    task automatic test_wrap();
        bq_t p;
        p = {8'hAA, 8'hBB};
        run_frame("wrap", 16'hFFFF, p, -1, 1'b0);
    endtask

    task automatic test_len_zero();
        bq_t p;
        p = {};
        run_frame("len_zero", 16'h1234, p, 8'hBA, 1'b0);
    endtask

    task automatic test_timeout();
        bq_t p;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h03);
        for (int k = 1; k < TO; k++) begin
            checks++;
            if ({err, busy} !== 2'b01) begin
                fails++;
                $display("FAIL timeout early cycle %0d: err/busy got %b expected 01", k, {err, busy});
            end
            step();
        end
        checks++;
        if ({err, busy, done, cpu_hold} !== 4'b1001) begin
            fails++;
            $display("FAIL timeout fire: err/busy/done/hold got %b expected 1001", {err, busy, done, cpu_hold});
        end
        // The sync of this frame lands in the very cycle the timeout fires.
        p = {8'h5A, 8'hA5, 8'h0F};
        run_frame("after_timeout", 16'h0040, p, -1, 1'b0);
    endtask

    task automatic test_reset_mid_data();
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        checks++;
        if ({w_en, w_addr, din} !== {1'b1, 16'h2001, 8'h02}) begin
            fails++;
            $display("FAIL rst_mid pre: wen/addr/din got %b/%h/%h expected 1/2001/02", w_en, w_addr, din);
        end
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h03;
        step();
        checks++;
        if ({rx_ready, w_en, w_addr, din, cpu_hold, busy, done, err} !== 30'h0) begin
            fails++;
            $display("FAIL rst_mid outputs: ready/wen/addr/din/hold/busy/done/err got %b/%b/%h/%h/%b/%b/%b/%b expected all 0",
                     rx_ready, w_en, w_addr, din, cpu_hold, busy, done, err);
        end
        rx_valid = 1'b0;
        rst      = 1'b0;
        send_byte(8'h04);
        checks++;
        if ({w_en, busy, done, err} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid tail: wen/busy/done/err got %b expected 0000", {w_en, busy, done, err});
        end
        send_byte(8'hD2);
        step();
        checks++;
        if ({w_en, busy, done, err, cpu_hold} !== 5'b00000) begin
            fails++;
            $display("FAIL rst_mid chk: wen/busy/done/err/hold got %b expected 00000",
                     {w_en, busy, done, err, cpu_hold});
        end
    endtask

    task automatic test_back_to_back();
        bq_t p;
        int  n;
        int  mode;
        for (int f = 0; f < 8; f++) begin
            p = {};
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            mode = ($urandom_range(0, 2) == 0) ? -2 : -1;
            run_frame($sformatf("rand%0d", f), 16'($urandom), p, mode, f[0]);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_wrap();
        test_len_zero();
        test_timeout();
        test_reset_mid_data();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial-stream loader that writes a program image into the instruction memory's write port (`w_addr`/`din`/`w_en`). It consumes a framed byte stream, typically from the UART receiver, and checks the framing and checksum. While a frame is being loaded, it holds the CPU in reset through `cpu_hold`. It sits between the byte source and the instruction RAM write side; the CPU keeps the read side.

## Interface
- `ADDR_WIDTH`, 16, instruction memory address width; the frame address is truncated to its low `ADDR_WIDTH` bits.
- `DATA_WIDTH`, 8, memory word width; fixed at 8, one byte per word.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT`, 50000, maximum idle cycles between bytes inside a frame.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_ready`  out  1  loader accepts a byte; a byte transfers when `rx_valid && rx_ready`.
- `w_addr`  out  ADDR_WIDTH  memory write address.
- `din`  out  DATA_WIDTH  memory write data.
- `w_en`  out  1  memory write strobe, one cycle per byte.
- `cpu_hold`  out  1  CPU reset request.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame passes its checksum.
- `err`  out  1  one-cycle pulse on a checksum failure or timeout.

## Operation
- Frame format: `SYNC_BYTE`, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes, CHK.
- Checksum rule: the 8-bit sum of every byte from ADDR_HI through CHK inclusive must equal 8'h00. `SYNC_BYTE` is excluded from the sum.
- States and transitions:
  - IDLE: non-`SYNC_BYTE` bytes are discarded; `SYNC_BYTE` moves to AH.
  - AH → AL → LH → LL: each accepted byte advances one state.
  - LL: goes to DATA, or to CHK if LEN==0.
  - DATA: one byte per write; moves to CHK after LEN bytes.
  - CHK: on a good checksum, pulses `done` and returns to IDLE; on a bad one, pulses `err` and returns to IDLE.
- `rx_ready` is constantly 1 outside reset, so the loader never stalls the source. During reset it is 0.
- Each payload byte produces one write at the current address; the address then increments modulo 2^ADDR_WIDTH, so wrap from max to 0 is legal.
- LEN is 16 bits; LEN greater than 2^ADDR_WIDTH simply overwrites earlier locations after wrap.
- Writes are not rolled back on a checksum error. `err` marks the image invalid.
- `cpu_hold`:
  - sets when `SYNC_BYTE` is accepted in IDLE;
  - clears one cycle after a `done` pulse;
  - stays set after `err`, and is cleared only by a later good frame or by `rst`.
- `busy` is 1 in every state except IDLE.
- Timeout: a counter resets on each accepted byte and counts while `busy` and no byte arrives. Reaching TIMEOUT pulses `err` and returns to IDLE; `cpu_hold` stays set.
- A `SYNC_BYTE` value inside a frame is ordinary data; there is no resync mid-frame.

## Timing
- Reset values: `rx_ready`=0, `w_en`=0, `w_addr`=0, `din`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0. State is IDLE and the timeout counter is 0.
- `rst` asserted mid-frame aborts the frame immediately. No further `w_en` is issued, and no `done`/`err` pulse is emitted.
- Write latency: a payload byte accepted in cycle N gives `w_en`=1 with the matching `w_addr`/`din` in cycle N+1. Back-to-back bytes give back-to-back writes.
- `done`/`err` rise the cycle after the CHK byte is accepted.
- `busy` falls in that same cycle.
- `cpu_hold` falls one cycle after `done` rises.
- `cpu_hold` rises the cycle after `SYNC_BYTE` is accepted.
- Timeout fires exactly TIMEOUT cycles after the last accepted byte; `err` is high in that cycle.
- A byte arriving in the cycle the timeout fires is treated as the first byte in IDLE.

## Structure
- Shared package holds:
  - the state enum (IDLE, AH, AL, LH, LL, DATA, CHK);
  - the default `SYNC_BYTE` value;
  - frame field constants.
- Sub-module `loader_timeout`: a loadable down-counter with clear and an expiry pulse, reusable by other serial blocks.
- Everything else is a single FSM with an address register, length counter and checksum accumulator.

## Test plan
- Good frame: A5 01 00 00 03 11 22 33 CHK with CHK=8'h96 → writes 11@0x0100, 22@0x0101, 33@0x0102; `done` pulses; `cpu_hold` 1 → 0.
- Bad checksum: same frame with CHK=8'h00 → three writes occur; `err` pulses; `cpu_hold` stays 1; `done` never asserts.
- Wrap-around: address 0xFFFF, LEN=2, payload AA BB → AA@0xFFFF, BB@0x0000, then `done`.
- LEN=0: A5 12 34 00 00 CHK with CHK=8'hBA → no `w_en`; `done` pulses.
- Timeout: stop after LEN_LO, TIMEOUT=16 → `err` pulses exactly 16 cycles after the last byte; state is IDLE; a following good frame succeeds.
- Reset mid-DATA: assert `rst` after 2 of 4 payload bytes → all outputs zero next cycle; no further writes; no pulses.
